// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================
// Package : mdu_pkg
// MDU op encodings and default latencies shared with decode/hazard logic.
// Rev     : 1.0
// ============================================================
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  localparam int MDU_MUL_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF = 10;

endpackage
`default_nettype wire

// File: rtl/mdu_hilo_if.sv
`default_nettype none
// ============================================================
// Interface : mdu_hilo_if
// Issue/result bundle between the EX stage and the MDU.
// Rev       : 1.0
// ============================================================
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, cancel, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, cancel, op, a, b,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mdu_divider.sv
`default_nettype none
// ============================================================
// Module : mdu_divider
// Combinational signed/unsigned divider: quotient, remainder, divide-by-zero.
// Rev    : 1.0
// ============================================================
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_signed,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_dz
);
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_den;
  logic [WIDTH-1:0] w_uq;
  logic [WIDTH-1:0] w_ur;

  assign o_dz    = (i_divisor == '0);
  assign w_neg_a = i_signed & i_dividend[WIDTH-1];
  assign w_neg_b = i_signed & i_divisor[WIDTH-1];
  assign w_abs_a = w_neg_a ? (-i_dividend) : i_dividend;
  assign w_abs_b = w_neg_b ? (-i_divisor) : i_divisor;
  // Substitute 1 on divide-by-zero; the caller discards the result anyway.
  assign w_den   = o_dz ? WIDTH'(1) : w_abs_b;
  assign w_uq    = w_abs_a / w_den;
  assign w_ur    = w_abs_a % w_den;

  // MIN/-1 falls out naturally: |MIN| wraps back to MIN after negation.
  assign o_quotient  = (w_neg_a ^ w_neg_b) ? (-w_uq) : w_uq;
  assign o_remainder = w_neg_a ? (-w_ur) : w_ur;
endmodule
`default_nettype wire

// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================
// Module : mdu_hilo
// Multi-cycle multiply/divide unit with HI/LO registers and cancel support.
// Rev    : 1.0
// ============================================================
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = MDU_MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  mdu_hilo_if.slave bus
);
  localparam int CNT_W =
    $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1);

  logic               r_busy;
  logic               r_done;
  logic               r_dz;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_pending;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_acc;
  logic               w_mul_signed;
  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_dz;

  assign w_acc = bus.start & ~bus.cancel & ~r_busy & (bus.op <= MDU_MTLO);

  // One 2*WIDTH multiplier serves both signednesses via operand extension.
  assign w_mul_signed = (bus.op == MDU_MULT);
  assign w_mul_a = {{WIDTH{w_mul_signed & bus.a[WIDTH-1]}}, bus.a};
  assign w_mul_b = {{WIDTH{w_mul_signed & bus.b[WIDTH-1]}}, bus.b};
  assign w_prod  = w_mul_a * w_mul_b;

  mdu_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .i_dividend  (bus.a),
    .i_divisor   (bus.b),
    .i_signed    (bus.op == MDU_DIV),
    .o_quotient  (w_quo),
    .o_remainder (w_rem),
    .o_dz        (w_dz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_cnt     <= '0;
      r_pending <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        if (r_cnt == '0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (!r_dz) begin
            {r_hi, r_lo} <= r_pending;
          end
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end else if (w_acc) begin
        case (bus.op)
          MDU_MULT, MDU_MULTU: begin
            r_pending <= w_prod;
            r_dz      <= 1'b0;
            r_busy    <= 1'b1;
            r_cnt     <= CNT_W'(MUL_CYCLES - 1);
          end
          MDU_DIV, MDU_DIVU: begin
            r_pending <= {w_rem, w_quo};
            r_dz      <= w_dz;
            r_busy    <= 1'b1;
            r_cnt     <= CNT_W'(DIV_CYCLES - 1);
          end
          MDU_MTHI: r_hi <= bus.a;
          MDU_MTLO: r_lo <= bus.a;
          default: ;
        endcase
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
// ============================================================
// Module : tb_mdu_hilo
// Scoreboard bench for mdu_hilo: default latencies and a 1/1-cycle variant.
// Rev    : 1.0
// ============================================================
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [63:0] sb1[$];
  logic [63:0] sb2[$];

  mdu_hilo_if #(.WIDTH(32)) bus1 ();
  mdu_hilo_if #(.WIDTH(32)) bus2 ();

  mdu_hilo #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  mdu_hilo #(.WIDTH(32), .MUL_CYCLES(1), .DIV_CYCLES(1)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] hilo(input int sel);
    return (sel == 1) ? {bus1.hi, bus1.lo} : {bus2.hi, bus2.lo};
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 1) ? bus1.busy : bus2.busy;
  endfunction

  // Drives one issue cycle; returns at the negedge after the sampling edge.
  task automatic issue(input int sel, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic cancel);
    @(negedge clk);
    if (sel == 1) begin
      bus1.start = 1'b1; bus1.cancel = cancel; bus1.op = op; bus1.a = a; bus1.b = b;
    end else begin
      bus2.start = 1'b1; bus2.cancel = cancel; bus2.op = op; bus2.a = a; bus2.b = b;
    end
    @(negedge clk);
    bus1.start = 1'b0; bus1.cancel = 1'b0;
    bus2.start = 1'b0; bus2.cancel = 1'b0;
  endtask

  // Counts remaining busy cycles (bounded); exp_n < 0 skips the length check.
  task automatic wait_idle(input int sel, input int exp_n, input string name);
    int n;
    n = 0;
    while (get_busy(sel) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (exp_n >= 0) chk(name, 64'(n), 64'(exp_n));
    else if (n >= 200) chk({name, "_timeout"}, 64'(n), 64'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus1.done) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL dut1_done: got unexpected done hilo=%h expected no done", {bus1.hi, bus1.lo});
      end else begin
        logic [63:0] e;
        e = sb1.pop_front();
        if ({bus1.hi, bus1.lo} !== e) begin
          errors++;
          $display("FAIL dut1_result: got %h expected %h", {bus1.hi, bus1.lo}, e);
        end
      end
    end
    if (bus2.done) begin
      checks++;
      if (sb2.size() == 0) begin
        errors++;
        $display("FAIL dut2_done: got unexpected done hilo=%h expected no done", {bus2.hi, bus2.lo});
      end else begin
        logic [63:0] e;
        e = sb2.pop_front();
        if ({bus2.hi, bus2.lo} !== e) begin
          errors++;
          $display("FAIL dut2_result: got %h expected %h", {bus2.hi, bus2.lo}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus1.start = 1'b0; bus1.cancel = 1'b0; bus1.op = 3'd0; bus1.a = '0; bus1.b = '0;
    bus2.start = 1'b0; bus2.cancel = 1'b0; bus2.op = 3'd0; bus2.a = '0; bus2.b = '0;
    repeat (2) @(negedge clk);
    chk("reset_hilo", hilo(1), 64'h0);
    chk("reset_busy_done", {62'd0, bus1.busy, bus1.done}, 64'd0);
    reset = 1'b0;

    // Multiplies
    sb1.push_back({32'hFFFFFFFF, 32'hFFFFFFFE});
    issue(1, MDU_MULT, 32'hFFFFFFFF, 32'h2, 1'b0);
    wait_idle(1, 5, "mult_busy_len");
    sb1.push_back({32'h00000001, 32'hFFFFFFFE});
    issue(1, MDU_MULTU, 32'hFFFFFFFF, 32'h2, 1'b0);
    wait_idle(1, 5, "multu_busy_len");

    // Divides
    sb1.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(1, MDU_DIV, 32'hFFFFFFF9, 32'h2, 1'b0);
    wait_idle(1, 10, "div_busy_len");
    sb1.push_back({32'h1, 32'h3});
    issue(1, MDU_DIVU, 32'h7, 32'h2, 1'b0);
    wait_idle(1, 10, "divu_busy_len");
    sb1.push_back({32'h1, 32'hFFFFFFFD});
    issue(1, MDU_DIV, 32'h7, 32'hFFFFFFFE, 1'b0);
    wait_idle(1, 10, "div_negdivisor_len");

    // Divide by zero keeps HI/LO
    issue(1, MDU_MTHI, 32'h1234, 32'h0, 1'b0);
    chk("mthi", hilo(1), {32'h1234, 32'hFFFFFFFD});
    chk("mthi_no_busy", {63'd0, bus1.busy}, 64'd0);
    issue(1, MDU_MTLO, 32'h5678, 32'h0, 1'b0);
    chk("mtlo", hilo(1), {32'h1234, 32'h5678});
    sb1.push_back({32'h1234, 32'h5678});
    issue(1, MDU_DIVU, 32'h7, 32'h0, 1'b0);
    wait_idle(1, 10, "divzero_busy_len");

    // Ops presented while busy are dropped
    sb1.push_back({32'h0, 32'd12});
    issue(1, MDU_MULT, 32'd3, 32'd4, 1'b0);
    issue(1, MDU_MULT, 32'd5, 32'd5, 1'b0);
    issue(1, MDU_MTLO, 32'hDEAD, 32'h0, 1'b0);
    wait_idle(1, -1, "busy_ignore");
    @(negedge clk);
    chk("after_busy_ignore", hilo(1), {32'h0, 32'd12});

    // Cancelled and reserved starts
    issue(1, MDU_DIV, 32'd100, 32'd7, 1'b1);
    chk("cancel_busy", {63'd0, bus1.busy}, 64'd0);
    chk("cancel_hilo", hilo(1), {32'h0, 32'd12});
    issue(1, 3'd6, 32'hAAAA, 32'h1, 1'b0);
    chk("reserved_busy", {63'd0, bus1.busy}, 64'd0);
    chk("reserved_hilo", hilo(1), {32'h0, 32'd12});

    // Asynchronous reset in the middle of a divide
    sb1.push_back(64'h0);
    issue(1, MDU_DIV, 32'd100, 32'd3, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_busy", {63'd0, bus1.busy}, 64'd0);
    chk("async_reset_hilo", hilo(1), 64'h0);
    sb1.delete();
    @(negedge clk);
    reset = 1'b0;
    issue(1, MDU_MTLO, 32'hAA, 32'h0, 1'b0);
    chk("mtlo_after_reset", hilo(1), {32'h0, 32'hAA});

    // Signed overflow
    sb1.push_back({32'h0, 32'h80000000});
    issue(1, MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle(1, 10, "ovf_busy_len");

    // Single-cycle latency instance
    sb2.push_back({32'h0, 32'd15});
    issue(2, MDU_MULT, 32'd3, 32'd5, 1'b0);
    wait_idle(2, 1, "fast_mult_len");
    sb2.push_back({32'h0, 32'h80000000});
    issue(2, MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle(2, 1, "fast_div_len");

    repeat (3) @(negedge clk);
    chk("sb1_drained", 64'(sb1.size()), 64'd0);
    chk("sb2_drained", 64'(sb2.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
